// File: rtl/dmem_ctrl.sv
// Word-organised data-memory controller for the rv32i core data port.
// Accepts one request at a time, models a configurable read latency and flags illegal accesses.
module dmem_ctrl #(
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ip_data_addr,
    input  logic        ip_data_wr,
    input  logic [3:0]  ip_data_mask,
    input  logic [31:0] ip_data_from_proc,
    input  logic        ip_data_rd,
    output logic        op_data_valid,
    output logic [31:0] op_data_to_proc,
    output logic        op_data_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] RESP    = 2'd2;

    localparam logic [3:0] CNT_LOAD = 4'(READ_LATENCY - 1);

    logic [31:0] mem [DEPTH];

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  err_q, err_d;
    logic [31:0]           rdata_q, rdata_d;

    logic                  req;
    logic                  illegal;
    logic                  wr_en;
    logic [31:0]           high_bits;
    logic [ADDR_WIDTH-1:0] req_idx;

    assign req       = ip_data_rd | ip_data_wr;
    assign high_bits = ip_data_addr >> (ADDR_WIDTH + 2);
    assign req_idx   = ip_data_addr[ADDR_WIDTH+1:2];
    assign illegal   = (ip_data_addr[1:0] != 2'b00) || (high_bits != 32'd0) ||
                       (ip_data_rd && ip_data_wr);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (illegal) begin
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                        state_d = RESP;
                    end else if (ip_data_wr) begin
                        err_d   = 1'b0;
                        wr_en   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d = 1'b0;
                        idx_d = req_idx;
                        if (READ_LATENCY == 1) begin
                            rdata_d = mem[req_idx];
                            state_d = RESP;
                        end else begin
                            cnt_d   = CNT_LOAD;
                            state_d = RD_WAIT;
                        end
                    end
                end
            end
            RD_WAIT: begin
                // The word is sampled on the edge where the counter hits zero,
                // so the read sees any update made during the wait.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    rdata_d = mem[idx_q];
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // RAM is not reset; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (wr_en && reset) begin
            for (int i = 0; i < 4; i++) begin
                if (ip_data_mask[i]) begin
                    mem[req_idx][8*i +: 8] <= ip_data_from_proc[8*i +: 8];
                end
            end
        end
    end

    assign op_data_valid   = (state_q == RESP);
    assign op_data_err     = (state_q == RESP) && err_q;
    assign op_data_to_proc = rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: four instances (READ_LATENCY 2, 1, 15, 4) share one request bus.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ip_data_addr;
    logic        ip_data_wr;
    logic [3:0]  ip_data_mask;
    logic [31:0] ip_data_from_proc;
    logic        ip_data_rd;

    logic [3:0]  v;
    logic [3:0]  e;
    logic [31:0] d [4];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.ADDR_WIDTH(10), .READ_LATENCY(2)) u_l2 (
        .clk(clk), .reset(reset), .ip_data_addr(ip_data_addr), .ip_data_wr(ip_data_wr),
        .ip_data_mask(ip_data_mask), .ip_data_from_proc(ip_data_from_proc), .ip_data_rd(ip_data_rd),
        .op_data_valid(v[0]), .op_data_to_proc(d[0]), .op_data_err(e[0]));

    dmem_ctrl #(.ADDR_WIDTH(10), .READ_LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset), .ip_data_addr(ip_data_addr), .ip_data_wr(ip_data_wr),
        .ip_data_mask(ip_data_mask), .ip_data_from_proc(ip_data_from_proc), .ip_data_rd(ip_data_rd),
        .op_data_valid(v[1]), .op_data_to_proc(d[1]), .op_data_err(e[1]));

    dmem_ctrl #(.ADDR_WIDTH(10), .READ_LATENCY(15)) u_l15 (
        .clk(clk), .reset(reset), .ip_data_addr(ip_data_addr), .ip_data_wr(ip_data_wr),
        .ip_data_mask(ip_data_mask), .ip_data_from_proc(ip_data_from_proc), .ip_data_rd(ip_data_rd),
        .op_data_valid(v[2]), .op_data_to_proc(d[2]), .op_data_err(e[2]));

    dmem_ctrl #(.ADDR_WIDTH(10), .READ_LATENCY(4)) u_l4 (
        .clk(clk), .reset(reset), .ip_data_addr(ip_data_addr), .ip_data_wr(ip_data_wr),
        .ip_data_mask(ip_data_mask), .ip_data_from_proc(ip_data_from_proc), .ip_data_rd(ip_data_rd),
        .op_data_valid(v[3]), .op_data_to_proc(d[3]), .op_data_err(e[3]));

    // Drives one request (called just after a rising edge with all instances idle),
    // measures edges from acceptance to valid on instance sel, then lets the bus go quiet.
    task automatic do_req(input int sel, input logic r, input logic w, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] mask,
                          output int lat, output logic [31:0] rdat, output logic rerr);
        ip_data_rd        = r;
        ip_data_wr        = w;
        ip_data_addr      = addr;
        ip_data_from_proc = wdata;
        ip_data_mask      = mask;
        lat  = -1;
        rdat = 32'hxxxx_xxxx;
        rerr = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (v[sel] === 1'b1) begin
                lat  = k;
                rdat = d[sel];
                rerr = e[sel];
                break;
            end
        end
        ip_data_rd = 1'b0;
        ip_data_wr = 1'b0;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ip_data_rd = 1'b0;
        ip_data_wr = 1'b0;
        ip_data_addr = 32'd0;
        ip_data_mask = 4'h0;
        ip_data_from_proc = 32'd0;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (v !== 4'b0000) $display("FAIL reset_valid got=%b want=0000", v);
        else passed++;
        total++;
        if (e !== 4'b0000) $display("FAIL reset_err got=%b want=0000", e);
        else passed++;
        total++;
        if (d[0] !== 32'd0) $display("FAIL reset_data got=%h want=00000000", d[0]);
        else passed++;
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] rd; logic er;
        do_req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, er);
        total++;
        if (lat !== 1) $display("FAIL wr_latency got=%0d want=1", lat);
        else passed++;
        total++;
        if (er !== 1'b0) $display("FAIL wr_err got=%b want=0", er);
        else passed++;
        do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
        total++;
        if (lat !== 2) $display("FAIL rd_latency got=%0d want=2", lat);
        else passed++;
        total++;
        if (rd !== 32'hDEADBEEF) $display("FAIL rd_data got=%h want=deadbeef", rd);
        else passed++;
        total++;
        if (er !== 1'b0) $display("FAIL rd_err got=%b want=0", er);
        else passed++;
    endtask

    task automatic test_byte_mask();
        int lat; logic [31:0] rd; logic er;
        do_req(0, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, lat, rd, er);
        do_req(0, 1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, lat, rd, er);
        total++;
        if (lat !== 1) $display("FAIL mask_wr_latency got=%0d want=1", lat);
        else passed++;
        do_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er);
        total++;
        if (rd !== 32'h11BB33DD) $display("FAIL mask_merge got=%h want=11bb33dd", rd);
        else passed++;
        do_req(0, 1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, lat, rd, er);
        total++;
        if (lat !== 1 || er !== 1'b0) $display("FAIL mask0_ack got lat=%0d err=%b want lat=1 err=0", lat, er);
        else passed++;
        do_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, lat, rd, er);
        total++;
        if (rd !== 32'h11BB33DD) $display("FAIL mask0_unchanged got=%h want=11bb33dd", rd);
        else passed++;
    endtask

    task automatic test_illegal();
        int lat; logic [31:0] rd; logic er;
        logic [31:0] addrs [5];
        logic        rds   [5];
        logic        wrs   [5];
        addrs = '{32'h13, 32'h1000, 32'h0, 32'h12, 32'h1010};
        rds   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        wrs   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_req(0, 1'b0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, lat, rd, er);
        for (int i = 0; i < 5; i++) begin
            do_req(0, rds[i], wrs[i], addrs[i], 32'hFFFFFFFF, 4'hF, lat, rd, er);
            total++;
            if (lat !== 1) $display("FAIL illegal%0d_latency got=%0d want=1", i, lat);
            else passed++;
            total++;
            if (er !== 1'b1) $display("FAIL illegal%0d_err got=%b want=1", i, er);
            else passed++;
            total++;
            if (rd !== 32'd0) $display("FAIL illegal%0d_data got=%h want=00000000", i, rd);
            else passed++;
        end
        do_req(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, lat, rd, er);
        total++;
        if (rd !== 32'h0BADF00D || er !== 1'b0) $display("FAIL illegal_word0 got=%h err=%b want=0badf00d err=0", rd, er);
        else passed++;
        do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
        total++;
        if (rd !== 32'hDEADBEEF) $display("FAIL illegal_word4 got=%h want=deadbeef", rd);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic exp;
        ip_data_rd   = 1'b1;
        ip_data_wr   = 1'b0;
        ip_data_addr = 32'h10;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            exp = ((i % 3) == 2);
            total++;
            if (v[0] !== exp) $display("FAIL b2b_valid cycle=%0d got=%b want=%b", i, v[0], exp);
            else passed++;
            if (exp) begin
                total++;
                if (d[0] !== 32'hDEADBEEF) $display("FAIL b2b_data cycle=%0d got=%h want=deadbeef", i, d[0]);
                else passed++;
            end
        end
        ip_data_rd = 1'b0;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic test_latency_sweep();
        int lat; logic [31:0] rd; logic er;
        do_req(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
        total++;
        if (lat !== 1 || rd !== 32'hDEADBEEF) $display("FAIL lat1 got lat=%0d data=%h want lat=1 data=deadbeef", lat, rd);
        else passed++;
        do_req(2, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
        total++;
        if (lat !== 15 || rd !== 32'hDEADBEEF) $display("FAIL lat15 got lat=%0d data=%h want lat=15 data=deadbeef", lat, rd);
        else passed++;
    endtask

    task automatic test_reset_mid_read();
        int lat; logic [31:0] rd; logic er;
        do_req(3, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er);
        total++;
        if (lat !== 4 || rd !== 32'h11BB33DD) $display("FAIL lat4 got lat=%0d data=%h want lat=4 data=11bb33dd", lat, rd);
        else passed++;
        ip_data_rd   = 1'b1;
        ip_data_addr = 32'h10;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (d[3] !== 32'd0) $display("FAIL rst_async_data got=%h want=00000000", d[3]);
        else passed++;
        total++;
        if (v[3] !== 1'b0 || e[3] !== 1'b0) $display("FAIL rst_async_flags got v=%b e=%b want 0 0", v[3], e[3]);
        else passed++;
        ip_data_rd = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            total++;
            if (v[3] !== 1'b0) $display("FAIL rst_no_valid cycle=%0d got=%b want=0", i, v[3]);
            else passed++;
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        do_req(3, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
        total++;
        if (lat !== 4) $display("FAIL rst_fresh_latency got=%0d want=4", lat);
        else passed++;
        total++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) $display("FAIL rst_ram_kept got=%h err=%b want=deadbeef err=0", rd, er);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_mask();
        test_illegal();
        test_back_to_back();
        test_latency_sweep();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller that sits directly downstream of the rv32i core's data port.
- It consumes the core's address, read/write strobes, byte mask and write data, and returns read data with a valid handshake.
- It holds a word-organised on-chip RAM, models a configurable read latency, and flags illegal accesses.
- Exactly one request is in flight at a time.

Parameters:
- ADDR_WIDTH, 10, log2 of RAM depth in 32-bit words (default 1024 words = 4 KiB).
- READ_LATENCY, 2, cycles from read acceptance to op_data_valid; legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- ip_data_addr  input  32  byte address from the core.
- ip_data_wr  input  1  write request, level, held by the core until valid.
- ip_data_mask  input  4  byte enables; bit i enables bits [8i+7:8i].
- ip_data_from_proc  input  32  write data.
- ip_data_rd  input  1  read request, level, held by the core until valid.
- op_data_valid  output  1  one-cycle completion pulse for the accepted request.
- op_data_to_proc  output  32  read data; meaningful only while op_data_valid=1.
- op_data_err  output  1  asserted only with op_data_valid; request was illegal and had no effect.

Behaviour:
- Reset (reset=0, asynchronous):
  - op_data_valid=0, op_data_err=0, op_data_to_proc=0.
  - FSM goes to IDLE and the latency counter clears to 0.
  - RAM contents are not reset.
  - Reset mid-operation abandons the request: no valid is produced and no partial write occurs.
- FSM states: IDLE, RD_WAIT, RESP.
- IDLE:
  - A request is accepted on any rising edge where ip_data_rd|ip_data_wr=1.
  - An accepted request is illegal if any of the following holds:
    - ip_data_addr[1:0]!=0;
    - ip_data_addr[31:ADDR_WIDTH+2]!=0;
    - ip_data_rd and ip_data_wr are both 1.
  - Illegal request: no RAM access; go to RESP with err=1, data=0.
  - Legal write: byte lanes with mask=1 of word ip_data_addr[ADDR_WIDTH+1:2] are written on the acceptance edge; go to RESP. A mask of 4'b0000 is legal, writes nothing, and is still acknowledged.
  - Legal read: the word index is captured, the counter is loaded with READ_LATENCY-1, and the FSM goes to RD_WAIT. If READ_LATENCY=1, it goes directly to RESP with the data captured.
- RD_WAIT:
  - The counter decrements each cycle.
  - When the counter reaches 0, the RAM word is registered into op_data_to_proc and the FSM goes to RESP.
  - RAM is read at the end of the wait, so a read returns the array contents at the completion cycle.
- RESP:
  - op_data_valid=1 for exactly this cycle. op_data_err is as determined at acceptance.
  - Next state is always IDLE. Inputs are ignored in RESP.
  - The core must drop or change its request in the cycle it sees valid. A request still held in the following IDLE cycle is treated as a new request.
- Latency from acceptance edge to the valid cycle:
  - write or illegal request: 1 cycle;
  - read: READ_LATENCY cycles.
- Back-to-back: the minimum spacing between acceptances is latency+1 cycles (the IDLE cycle is mandatory).
- Request inputs are sampled only in IDLE. Changes to the inputs while in RD_WAIT or RESP have no effect.
- op_data_to_proc holds its last value after valid drops. It is 0 after reset and after an error response.
- Read data is the full 32-bit word. The mask is ignored on reads; sub-word extraction is the core's job.

Test Plan:
- Write 0xDEADBEEF to addr 0x10 with mask 4'hF, then read 0x10 (READ_LATENCY=2) -> write valid 1 cycle after acceptance; read valid exactly 2 cycles after acceptance with data 0xDEADBEEF, err=0.
- Write 0x11223344 (mask 4'hF) to 0x20, then 0xAABBCCDD with mask 4'b0101, then read -> 0x11BB33DD. A mask 4'b0000 write is acknowledged and leaves the word unchanged.
- Read at 0x13 (misaligned), read at 0x1000 (out of range, ADDR_WIDTH=10), and rd=wr=1 at 0x0 -> each gives valid+err 1 cycle after acceptance, data 0, and memory unchanged (confirm by a subsequent legal read).
- Hold ip_data_rd=1 for 0x10 continuously -> valid pulses every READ_LATENCY+1 cycles, never on consecutive cycles.
- Sweep READ_LATENCY=1 and 15 -> valid at exactly 1 and 15 cycles after acceptance respectively.
- Assert reset low one cycle into a READ_LATENCY=4 read -> outputs go to 0 immediately (asynchronously); no valid after release; the FSM accepts a fresh request on the first edge after release.
